// File: rtl/addsub_sat_pipe.sv
// ---------------------------------------------------------------------------
// addsub_sat_pipe
//
// Pipelined signed add/subtract. The WIDTH-bit carry chain is cut into
// SEG-bit segments, and each pipeline stage resolves one segment, so the
// pipeline depth is NSTG = WIDTH/SEG. An op carries its tag, N/Z/V flags and
// a valid bit through the pipe. Issue rate is one op per cycle.
//
// Optional feature (compile-time macro ADDSUB_SAT_EN):
//   defined   - on signed overflow, out_result clamps to the most positive
//               or most negative value
//   undefined - out_result is the raw wrapped sum
//   out_v always reports the raw overflow, whichever build is used.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready input handshake
//   in_a, in_b        signed operands (WIDTH)
//   in_sub            0: a+b, 1: a-b
//   in_tag            tag returned unchanged with the result (TAG_W)
//   out_valid/out_ready output handshake
//   out_result        result (WIDTH)
//   out_tag           tag of the result
//   out_n, out_z      sign and zero of out_result (after any clamping)
//   out_v             signed overflow of the raw operation
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. While valid is high and ready is low, the producer keeps its
// payload stable. The pipe advances whenever the output register is empty or
// is being drained, so in_ready = !out_valid | out_ready. When the pipe does
// not advance, every stage holds (bubbles are kept as bubbles).
//
// Latency: an op accepted on edge E shows up on out_valid after edge E+NSTG.
// WIDTH must be a multiple of SEG.
// ---------------------------------------------------------------------------
module addsub_sat_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_n,
    output logic             out_z,
    output logic             out_v
);
    localparam int NSTG = WIDTH / SEG;

    logic advance;

    // Stage register k holds an op whose segments 0..k-1 are already summed.
    // st_b holds the effective B (already inverted for subtraction).
    // st_c is the carry into segment k.
    logic             st_v   [NSTG];
    logic [WIDTH-1:0] st_a   [NSTG];
    logic [WIDTH-1:0] st_b   [NSTG];
    logic [WIDTH-1:0] st_sum [NSTG];
    logic             st_c   [NSTG];
    logic [TAG_W-1:0] st_tag [NSTG];

    // Combinational result of stage k, which is segment k added in
    logic [SEG:0]     nx_seg [NSTG];
    logic [WIDTH-1:0] nx_sum [NSTG];
    logic             nx_c   [NSTG];

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] fin_res;
    logic             fin_v;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            nx_seg[k] = {1'b0, st_a[k][k*SEG +: SEG]}
                      + {1'b0, st_b[k][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, st_c[k]};
            nx_sum[k] = st_sum[k];
            nx_sum[k][k*SEG +: SEG] = nx_seg[k][SEG-1:0];
            nx_c[k] = nx_seg[k][SEG];
        end
    end

    assign raw_sum = nx_sum[NSTG-1];

    // Overflow means both operand signs agree but the sum sign differs
    assign fin_v = (st_a[NSTG-1][WIDTH-1] == st_b[NSTG-1][WIDTH-1])
                && (raw_sum[WIDTH-1] != st_a[NSTG-1][WIDTH-1]);

`ifdef ADDSUB_SAT_EN
    // The direction of the clamp follows the sign of A, which equals the
    // sign of effective B whenever overflow is possible
    always_comb begin
        fin_res = raw_sum;
        if (fin_v) begin
            fin_res = st_a[NSTG-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign fin_res = raw_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                st_v[k] <= 1'b0;
            end
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_n      <= 1'b0;
            out_z      <= 1'b0;
            out_v      <= 1'b0;
        end else if (advance) begin
            st_v[0]   <= in_valid;
            st_a[0]   <= in_a;
            st_b[0]   <= in_sub ? ~in_b : in_b;
            st_sum[0] <= '0;
            st_c[0]   <= in_sub;
            st_tag[0] <= in_tag;
            for (int k = 1; k < NSTG; k++) begin
                st_v[k]   <= st_v[k-1];
                st_a[k]   <= st_a[k-1];
                st_b[k]   <= st_b[k-1];
                st_sum[k] <= nx_sum[k-1];
                st_c[k]   <= nx_c[k-1];
                st_tag[k] <= st_tag[k-1];
            end
            out_valid <= st_v[NSTG-1];
            // A bubble leaves the last delivered result and flags as they were
            if (st_v[NSTG-1]) begin
                out_result <= fin_res;
                out_tag    <= st_tag[NSTG-1];
                out_n      <= fin_res[WIDTH-1];
                out_z      <= (fin_res == '0);
                out_v      <= fin_v;
            end
        end
    end

endmodule
